// File: rtl/pkt_tx_pkg.sv
// Shared widths, FSM state type and empty-count helper for the packet transmitter.
package pkt_tx_pkg;

  localparam int unsigned SYMBOLS_DFLT = 64;
  localparam int unsigned DATA_W       = SYMBOLS_DFLT * 8;
  localparam int unsigned EMPTY_W      = $clog2(SYMBOLS_DFLT);
  localparam int unsigned LEN_W        = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Unused symbol slots in the final flit of a packet of 'len' bytes.
  function automatic logic [LEN_W-1:0] calc_empty(input logic [LEN_W-1:0] len,
                                                   input int unsigned      spb);
    int unsigned rmd;
    rmd = 32'(len) % spb;
    return LEN_W'((spb - rmd) % spb);
  endfunction

endpackage

// File: rtl/avl_stream_if.sv
// Avalon-ST style stream link with sink-side almost_full back-pressure hint.
interface avl_stream_if #(
  parameter int unsigned DATA_W  = 512,
  parameter int unsigned EMPTY_W = 6
);
  logic [DATA_W-1:0]  data;
  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic               almost_full;

  modport tx (output data, valid, sop, eop, empty, input ready, almost_full);
  modport rx (input data, valid, sop, eop, empty, output ready, almost_full);
endinterface

// File: rtl/pkt_tx_payload.sv
// Builds one flit of the incrementing byte pattern; slots past nbytes are zero.
module pkt_tx_payload #(
  parameter int unsigned SYMBOLS = 64,
  parameter int unsigned NB_W    = $clog2(SYMBOLS + 1)
) (
  input  logic [7:0]           base,
  input  logic [NB_W-1:0]      nbytes,
  output logic [SYMBOLS*8-1:0] flit
);

  // Symbol 0 sits in the most significant byte lane.
  always_comb begin
    flit = '0;
    for (int unsigned i = 0; i < SYMBOLS; i++) begin
      if (NB_W'(i) < nbytes) begin
        flit[SYMBOLS*8-1-8*i -: 8] = base + 8'(i);
      end
    end
  end

endmodule

// File: rtl/avlstrm_pkt_tx.sv
// Avalon-ST packet transmitter: turns (length, seed) commands into sop/eop flit trains.
module avlstrm_pkt_tx
  import pkt_tx_pkg::*;
#(
  parameter int unsigned SYMBOLS_PER_BEAT = 64,
  parameter int unsigned BITS_PER_SYMBOL  = 8,
  parameter int unsigned USE_ALMOST_FULL  = 0,
  parameter int unsigned MAX_PKT_BYTES    = 9216
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       cmd_seed,
  avl_stream_if.tx         out,
  output logic             busy,
  output logic [31:0]      stats_pkt,
  output logic [31:0]      stats_flit,
  output logic [31:0]      stats_err
);

  localparam int unsigned    DW    = SYMBOLS_PER_BEAT * BITS_PER_SYMBOL;
  localparam int unsigned    EW    = $clog2(SYMBOLS_PER_BEAT);
  localparam int unsigned    NB_W  = $clog2(SYMBOLS_PER_BEAT + 1);
  localparam logic [LEN_W-1:0] SPB_L = LEN_W'(SYMBOLS_PER_BEAT);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       base_q, base_d;
  logic             valid_q, valid_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;
  logic [EW-1:0]    empty_q, empty_d;
  logic [DW-1:0]    data_q, data_d;
  logic [31:0]      pkt_q, pkt_d;
  logic [31:0]      flit_q, flit_d;
  logic [31:0]      err_q, err_d;

  logic             gate_c, xfer_c, legal_c, accept_c, use_cmd_c, ld_last_c;
  logic [LEN_W-1:0] ld_len_c;
  logic [7:0]       ld_base_c;
  logic [NB_W-1:0]  ld_nb_c;
  logic [DW-1:0]    ld_flit_c;

  assign gate_c   = (USE_ALMOST_FULL != 0) && out.almost_full;
  assign xfer_c   = valid_q & out.ready;
  assign legal_c  = (cmd_len != '0) && (32'(cmd_len) <= MAX_PKT_BYTES);
  assign accept_c = cmd_valid & cmd_ready;

  // In SEND a new command can only ride on the eop transfer (zero-bubble restart).
  always_comb begin
    cmd_ready = 1'b0;
    if (!Rst) begin
      if (state_q == IDLE) cmd_ready = ~gate_c;
      else                 cmd_ready = xfer_c & eop_q & ~gate_c;
    end
  end

  // Next-flit source: a fresh command, or the continuation of the current packet.
  assign use_cmd_c = (state_q == IDLE) | eop_q;
  assign ld_len_c  = use_cmd_c ? cmd_len  : rem_q - SPB_L;
  assign ld_base_c = use_cmd_c ? cmd_seed : base_q + 8'(SYMBOLS_PER_BEAT);
  assign ld_last_c = ld_len_c <= SPB_L;
  assign ld_nb_c   = ld_last_c ? NB_W'(ld_len_c) : NB_W'(SYMBOLS_PER_BEAT);

  pkt_tx_payload #(
    .SYMBOLS (SYMBOLS_PER_BEAT),
    .NB_W    (NB_W)
  ) u_payload (
    .base   (ld_base_c),
    .nbytes (ld_nb_c),
    .flit   (ld_flit_c)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    base_d  = base_q;
    valid_d = valid_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    empty_d = empty_q;
    data_d  = data_q;
    pkt_d   = pkt_q;
    flit_d  = flit_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c && !legal_c) err_d = err_q + 32'd1;
      end
      SEND: begin
        if (xfer_c) begin
          flit_d = flit_q + 32'd1;
          if (eop_q) begin
            pkt_d = pkt_q + 32'd1;
            if (accept_c && !legal_c) err_d = err_q + 32'd1;
            if (!(accept_c && legal_c)) begin
              state_d = IDLE;
              valid_d = 1'b0;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
              empty_d = '0;
              data_d  = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Load a new flit on command acceptance or on a mid-packet transfer.
    if ((accept_c && legal_c) || (state_q == SEND && xfer_c && !eop_q)) begin
      state_d = SEND;
      rem_d   = ld_len_c;
      base_d  = ld_base_c;
      valid_d = 1'b1;
      sop_d   = use_cmd_c;
      eop_d   = ld_last_c;
      empty_d = ld_last_c ? EW'(calc_empty(ld_len_c, SYMBOLS_PER_BEAT)) : '0;
      data_d  = ld_flit_c;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      base_q  <= '0;
      valid_q <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      empty_q <= '0;
      data_q  <= '0;
      pkt_q   <= '0;
      flit_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      base_q  <= base_d;
      valid_q <= valid_d;
      sop_q   <= sop_d;
      eop_q   <= eop_d;
      empty_q <= empty_d;
      data_q  <= data_d;
      pkt_q   <= pkt_d;
      flit_q  <= flit_d;
      err_q   <= err_d;
    end
  end

  assign out.data  = data_q;
  assign out.valid = valid_q;
  assign out.sop   = sop_q;
  assign out.eop   = eop_q;
  assign out.empty = empty_q;

  assign busy       = (state_q == SEND);
  assign stats_pkt  = pkt_q;
  assign stats_flit = flit_q;
  assign stats_err  = err_q;

endmodule

// File: tb/tb_avlstrm_pkt_tx.sv
// Directed bench for avlstrm_pkt_tx with almost_full gating enabled.
module tb_avlstrm_pkt_tx;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_len;
  logic [7:0]  cmd_seed;
  logic        busy;
  logic [31:0] stats_pkt, stats_flit, stats_err;

  int n_chk  = 0;
  int n_fail = 0;
  int e_pkt  = 0;
  int e_flit = 0;
  int e_err  = 0;

  avl_stream_if #(.DATA_W(512), .EMPTY_W(6)) s_if ();

  avlstrm_pkt_tx #(
    .SYMBOLS_PER_BEAT (64),
    .BITS_PER_SYMBOL  (8),
    .USE_ALMOST_FULL  (1),
    .MAX_PKT_BYTES    (9216)
  ) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_len    (cmd_len),
    .cmd_seed   (cmd_seed),
    .out        (s_if),
    .busy       (busy),
    .stats_pkt  (stats_pkt),
    .stats_flit (stats_flit),
    .stats_err  (stats_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] exp_flit(input int len, input logic [7:0] seed, input int idx);
    logic [511:0] f;
    int k;
    f = '0;
    for (int j = 0; j < 64; j++) begin
      k = idx * 64 + j;
      if (k < len) f[511-8*j -: 8] = seed + 8'(k);
    end
    return f;
  endfunction

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_pkt"},  stats_pkt,  32'(e_pkt));
    chk({tag, "_flit"}, stats_flit, 32'(e_flit));
    chk({tag, "_err"},  stats_err,  32'(e_err));
  endtask

  // Offer a command at a negedge while IDLE; returns at the negedge the first flit shows.
  task automatic issue(input logic [15:0] len, input logic [7:0] seed);
    cmd_valid = 1'b1;
    cmd_len   = len;
    cmd_seed  = seed;
    #1;
    chk("issue_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
  endtask

  // Consume and check one packet; optionally offer the next command on its eop transfer.
  task automatic drain(input int len, input logic [7:0] seed, input bit rnd,
                       input bit nxt, input logic [15:0] nlen, input logic [7:0] nseed);
    int nfl, idx, cyc;
    bit stalled, last;
    logic [511:0] hold_d;
    logic [31:0]  hold_f;
    nfl = (len + 63) / 64;
    idx = 0; cyc = 0; stalled = 1'b0; hold_d = '0; hold_f = '0;
    while (idx < nfl && cyc < 400) begin
      chk("valid", 32'(s_if.valid), 32'd1);
      if (s_if.valid !== 1'b1) break;
      if (stalled) begin
        chkd("stall_data", s_if.data, hold_d);
        chk("stall_flit", stats_flit, hold_f);
      end
      s_if.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      last = (idx == nfl - 1);
      if (s_if.ready) begin
        chkd("data", s_if.data, exp_flit(len, seed, idx));
        chk("sop", 32'(s_if.sop), 32'(idx == 0));
        chk("eop", 32'(s_if.eop), 32'(last));
        chk("empty", 32'(s_if.empty), last ? 32'(nfl * 64 - len) : 32'd0);
        if (last && nxt) begin
          cmd_valid = 1'b1;
          cmd_len   = nlen;
          cmd_seed  = nseed;
          #1;
          chk("b2b_cmd_ready", 32'(cmd_ready), 32'd1);
        end
        idx++;
        e_flit++;
        stalled = 1'b0;
      end else begin
        hold_d  = s_if.data;
        hold_f  = stats_flit;
        stalled = 1'b1;
      end
      step();
      cyc++;
    end
    cmd_valid  = 1'b0;
    s_if.ready = 1'b1;
    chk("flit_count", 32'(idx), 32'(nfl));
    e_pkt++;
  endtask

  logic [511:0] d;

  initial begin
    Rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; cmd_seed = '0;
    s_if.ready = 1'b1; s_if.almost_full = 1'b0;

    // Reset state
    step(); step();
    chk("rst_valid", 32'(s_if.valid), 32'd0);
    chk("rst_sop_eop", {30'd0, s_if.sop, s_if.eop}, 32'd0);
    chk("rst_empty", 32'(s_if.empty), 32'd0);
    chkd("rst_data", s_if.data, 512'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk_stats("rst");
    Rst = 1'b0;
    step();

    // Single 64-byte packet, seed 0x10
    issue(16'd64, 8'h10);
    chk("t1_busy", 32'(busy), 32'd1);
    d = s_if.data;
    chk("t1_byte0", 32'(d[511:504]), 32'h10);
    chk("t1_byte63", 32'(d[7:0]), 32'h4F);
    drain(64, 8'h10, 1'b0, 1'b0, '0, '0);
    chk("t1_idle_valid", 32'(s_if.valid), 32'd0);
    chk_stats("t1");

    // 130 bytes, seed 0xF0: three flits, wrap inside flit 0
    issue(16'd130, 8'hF0);
    d = s_if.data;
    chk("t2_sop0", {30'd0, s_if.sop, s_if.eop}, 32'd2);
    chk("t2_byte15", 32'(d[391:384]), 32'hFF);
    chk("t2_byte16", 32'(d[383:376]), 32'h00);
    step();
    chkd("t2_flit1", s_if.data, exp_flit(130, 8'hF0, 1));
    chk("t2_sop1", {30'd0, s_if.sop, s_if.eop}, 32'd0);
    step();
    d = s_if.data;
    chk("t2_eop2", {30'd0, s_if.sop, s_if.eop}, 32'd1);
    chk("t2_empty2", 32'(s_if.empty), 32'd62);
    chk("t2_bytes128", 32'(d[511:496]), 32'h7071);
    chkd("t2_tail", d & {16'h0, {496{1'b1}}}, 512'd0);
    step();
    e_flit += 3; e_pkt++;
    chk("t2_idle_valid", 32'(s_if.valid), 32'd0);
    chk_stats("t2");

    // 1000 bytes with random ready
    issue(16'd1000, 8'h5A);
    drain(1000, 8'h5A, 1'b1, 1'b0, '0, '0);
    chk("t3_flit_delta", stats_flit, 32'(e_flit));
    chk_stats("t3");

    // Back-to-back 64 then 65 with no bubble
    issue(16'd64, 8'h20);
    drain(64, 8'h20, 1'b0, 1'b1, 16'd65, 8'h40);
    chk("t4_sop_next", 32'(s_if.sop), 32'd1);
    drain(65, 8'h40, 1'b0, 1'b0, '0, '0);
    chk("t4_idle_valid", 32'(s_if.valid), 32'd0);
    chk_stats("t4");

    // almost_full mid-packet does not stall; blocks a start while high
    issue(16'd200, 8'h33);
    s_if.almost_full = 1'b1;
    drain(200, 8'h33, 1'b0, 1'b0, '0, '0);
    cmd_valid = 1'b1; cmd_len = 16'd64; cmd_seed = 8'hC0;
    #1;
    chk("t5_cmd_ready_af", 32'(cmd_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_no_sop", {30'd0, s_if.valid, busy}, 32'd0);
    end
    s_if.almost_full = 1'b0;
    #1;
    chk("t5_cmd_ready_clr", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    drain(64, 8'hC0, 1'b0, 1'b0, '0, '0);
    chk_stats("t5");

    // Illegal lengths are accepted and dropped
    cmd_valid = 1'b1; cmd_len = 16'd0; cmd_seed = 8'h01;
    #1;
    chk("t6_ready_len0", 32'(cmd_ready), 32'd1);
    step();
    cmd_len = 16'd9217;
    #1;
    chk("t6_ready_len9217", 32'(cmd_ready), 32'd1);
    step();
    cmd_valid = 1'b0;
    e_err += 2;
    chk("t6_valid", {30'd0, s_if.valid, busy}, 32'd0);
    chk_stats("t6");

    // Reset mid-packet, then a clean 64-byte packet
    issue(16'd300, 8'h01);
    step();
    s_if.ready = 1'b0;
    #2;
    Rst = 1'b1;
    #1;
    chk("t7_rst_valid", 32'(s_if.valid), 32'd0);
    chk("t7_rst_busy", 32'(busy), 32'd0);
    chkd("t7_rst_data", s_if.data, 512'd0);
    chk("t7_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    e_pkt = 0; e_flit = 0; e_err = 0;
    chk_stats("t7_rst");
    @(negedge Clk);
    Rst = 1'b0;
    s_if.ready = 1'b1;
    issue(16'd64, 8'hA5);
    drain(64, 8'hA5, 1'b0, 1'b0, '0, '0);
    chk_stats("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
